// File: rtl/decrypt_pkg.sv
// Shared definitions for the LWE decrypt controller.
//
// Holds the controller state encoding, the default LWE parameter set, the
// rounding constants that map a mod-q accumulator onto a mod-p plaintext,
// and helpers that size index/address fields from the dimension.
package decrypt_pkg;

    // Default parameter set: p = 2^6, q = 2^10, n = 10.
    localparam int DEF_PLAINTEXT_WIDTH  = 6;
    localparam int DEF_CIPHERTEXT_WIDTH = 10;
    localparam int DEF_DIMENSION        = 10;

    // Rounding maps an acc in [0, q) onto round(acc * p / q) mod p.
    // Shifting by CW-PW divides by q/p; adding half of that step first rounds.
    function automatic int round_shift(input int cw, input int pw);
        return cw - pw;
    endfunction

    function automatic int round_half(input int cw, input int pw);
        return 1 << (cw - pw - 1);
    endfunction

    localparam int ROUND_SHIFT = round_shift(DEF_CIPHERTEXT_WIDTH, DEF_PLAINTEXT_WIDTH);
    localparam int ROUND_HALF  = round_half(DEF_CIPHERTEXT_WIDTH, DEF_PLAINTEXT_WIDTH);

    // Width of a field able to index n distinct entries (at least 1 bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        DRAIN = 3'd2,
        ROUND = 3'd3,
        OUT   = 3'd4
    } state_e;

endpackage

// File: rtl/decrypt_mac.sv
// Mod-q accumulator for b - <a,s>.
//
// Each returned memory beat is either a (a_i, s_i) pair, which is multiplied
// and subtracted, or the b term (tag == DIMENSION), which is added. All
// arithmetic is on CW-bit unsigned residues, so wrap-around is exactly mod q.
//
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   clear_i    zero the accumulator (start of a new decryption)
//   valid_i    a memory beat is present on ct_data_i / sk_data_i
//   tag_i      index the beat was issued for
//   ct_data_i  ciphertext entry (a_i or b)
//   sk_data_i  key entry s_i (ignored for the b beat)
//   acc_o      current accumulator value
module decrypt_mac
    import decrypt_pkg::*;
#(
    parameter int CIPHERTEXT_WIDTH = DEF_CIPHERTEXT_WIDTH,
    parameter int DIMENSION        = DEF_DIMENSION,
    parameter int IDX_WIDTH        = idx_width(DEF_DIMENSION + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear_i,
    input  logic                        valid_i,
    input  logic [IDX_WIDTH-1:0]        tag_i,
    input  logic [CIPHERTEXT_WIDTH-1:0] ct_data_i,
    input  logic [CIPHERTEXT_WIDTH-1:0] sk_data_i,
    output logic [CIPHERTEXT_WIDTH-1:0] acc_o
);

    localparam logic [IDX_WIDTH-1:0] B_TAG = IDX_WIDTH'(DIMENSION);

    logic [CIPHERTEXT_WIDTH-1:0] acc_q, acc_d;
    logic [CIPHERTEXT_WIDTH-1:0] prod_lo;

    // Only the low CW bits of a_i * s_i matter mod q.
    assign prod_lo = ct_data_i * sk_data_i;

    always_comb begin
        acc_d = acc_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (valid_i) begin
            if (tag_i == B_TAG) begin
                acc_d = acc_q + ct_data_i;
            end else begin
                acc_d = acc_q - prod_lo;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/decrypt_controller.sv
// LWE decryption sequencer.
//
// One start request walks ciphertext index 0..DIMENSION (key index
// 0..DIMENSION-1) through the single-port memories, accumulates
// b - <a,s> mod q, rounds the sum to a plaintext mod p and presents it on
// a valid/ready output.
//
// Handshake: result is offered with result_valid high and held stable until
// the cycle result_ready is also high; that cycle completes the transfer and
// the block returns to IDLE. start is only looked at in IDLE, so requests
// while busy (including the handshake cycle) are dropped.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               request one decryption
//   busy                high whenever not IDLE
//   sk_rd_en/sk_addr    key memory read port, data on sk_rd_data next cycle
//   ct_rd_en/ct_addr    ciphertext memory read port, data on ct_rd_data next cycle
//   result              decrypted plaintext
//   result_valid/ready  output handshake
module decrypt_controller
    import decrypt_pkg::*;
#(
    parameter int PLAINTEXT_MODULUS  = 64,
    parameter int PLAINTEXT_WIDTH    = DEF_PLAINTEXT_WIDTH,
    parameter int CIPHERTEXT_MODULUS = 1024,
    parameter int CIPHERTEXT_WIDTH   = DEF_CIPHERTEXT_WIDTH,
    parameter int DIMENSION          = DEF_DIMENSION
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    output logic                               busy,
    output logic                               sk_rd_en,
    output logic [$clog2(DIMENSION)-1:0]       sk_addr,
    input  logic [CIPHERTEXT_WIDTH-1:0]        sk_rd_data,
    output logic                               ct_rd_en,
    output logic [$clog2(DIMENSION+1)-1:0]     ct_addr,
    input  logic [CIPHERTEXT_WIDTH-1:0]        ct_rd_data,
    output logic [PLAINTEXT_WIDTH-1:0]         result,
    output logic                               result_valid,
    input  logic                               result_ready
);

    localparam int IW    = $clog2(DIMENSION + 1);
    localparam int SKW   = $clog2(DIMENSION);
    localparam int SHIFT = round_shift(CIPHERTEXT_WIDTH, PLAINTEXT_WIDTH);

    localparam logic [IW-1:0]               LAST_IDX = IW'(DIMENSION);
    localparam logic [CIPHERTEXT_WIDTH-1:0] HALF_C   =
        CIPHERTEXT_WIDTH'(round_half(CIPHERTEXT_WIDTH, PLAINTEXT_WIDTH));

    state_e                      state_q, state_d;
    logic [IW-1:0]               index_q, index_d;
    logic [PLAINTEXT_WIDTH-1:0]  result_q, result_d;
    logic                        beat_valid_q, beat_valid_d;
    logic [IW-1:0]               beat_tag_q, beat_tag_d;
    logic                        acc_clear;
    logic [CIPHERTEXT_WIDTH-1:0] acc;

    always_comb begin
        state_d      = state_q;
        index_d      = index_q;
        result_d     = result_q;
        acc_clear    = 1'b0;
        busy         = 1'b1;
        sk_rd_en     = 1'b0;
        sk_addr      = '0;
        ct_rd_en     = 1'b0;
        ct_addr      = '0;
        result_valid = 1'b0;
        // A read issued this cycle comes back next cycle, tagged with its index.
        beat_valid_d = 1'b0;
        beat_tag_d   = index_q;

        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d   = FETCH;
                    index_d   = '0;
                    acc_clear = 1'b1;
                end
            end
            FETCH: begin
                ct_rd_en     = 1'b1;
                ct_addr      = index_q;
                beat_valid_d = 1'b1;
                // The key has no entry at index n; that read fetches b only.
                if (index_q < LAST_IDX) begin
                    sk_rd_en = 1'b1;
                    sk_addr  = index_q[SKW-1:0];
                end
                index_d = index_q + IW'(1);
                if (index_q == LAST_IDX) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // The b beat lands in the accumulator at the end of this cycle.
                state_d = ROUND;
            end
            ROUND: begin
                // Sum is taken mod q, so the top-end round wraps to plaintext 0.
                result_d = PLAINTEXT_WIDTH'((acc + HALF_C) >> SHIFT);
                state_d  = OUT;
            end
            OUT: begin
                result_valid = 1'b1;
                if (result_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            index_q      <= '0;
            result_q     <= '0;
            beat_valid_q <= 1'b0;
            beat_tag_q   <= '0;
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            result_q     <= result_d;
            beat_valid_q <= beat_valid_d;
            beat_tag_q   <= beat_tag_d;
        end
    end

    assign result = result_q;

    decrypt_mac #(
        .CIPHERTEXT_WIDTH (CIPHERTEXT_WIDTH),
        .DIMENSION        (DIMENSION),
        .IDX_WIDTH        (IW)
    ) u_mac (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (acc_clear),
        .valid_i   (beat_valid_q),
        .tag_i     (beat_tag_q),
        .ct_data_i (ct_rd_data),
        .sk_data_i (sk_rd_data),
        .acc_o     (acc)
    );

endmodule

// File: tb/tb_decrypt_controller.sv
module tb_decrypt_controller;

    localparam int DIM = 10;
    localparam int CW  = 10;
    localparam int PW  = 6;
    localparam int Q   = 1024;
    localparam int P   = 64;
    localparam int EXP_EDGE = DIM + 4;

    logic          clk;
    logic          rst;
    logic          start;
    logic          busy;
    logic          sk_rd_en;
    logic [3:0]    sk_addr;
    logic [CW-1:0] sk_rd_data;
    logic          ct_rd_en;
    logic [3:0]    ct_addr;
    logic [CW-1:0] ct_rd_data;
    logic [PW-1:0] result;
    logic          result_valid;
    logic          result_ready;

    int checks   = 0;
    int failures = 0;

    logic [CW-1:0] sk_mem [DIM];
    logic [CW-1:0] ct_mem [DIM+1];
    logic [3:0]    ct_log [$];
    logic [3:0]    sk_log [$];

    decrypt_controller dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .busy         (busy),
        .sk_rd_en     (sk_rd_en),
        .sk_addr      (sk_addr),
        .sk_rd_data   (sk_rd_data),
        .ct_rd_en     (ct_rd_en),
        .ct_addr      (ct_addr),
        .ct_rd_data   (ct_rd_data),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory models + read log ----------------
    always @(posedge clk) begin
        if (sk_rd_en) begin
            sk_rd_data <= sk_mem[sk_addr];
            sk_log.push_back(sk_addr);
        end
        if (ct_rd_en) begin
            ct_rd_data <= ct_mem[ct_addr];
            ct_log.push_back(ct_addr);
        end
    end

    // ---------------- reference model ----------------
    // plaintext = round((b - sum a_i*s_i mod q) * p / q) mod p
    function automatic int model_result();
        int acc;
        acc = int'(ct_mem[DIM]);
        for (int i = 0; i < DIM; i++) acc = acc - int'(ct_mem[i]) * int'(sk_mem[i]);
        acc = ((acc % Q) + Q) % Q;
        return ((acc + Q / (2 * P)) / (Q / P)) % P;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic load_random();
        for (int i = 0; i < DIM; i++) sk_mem[i] = CW'($urandom_range(0, Q - 1));
        for (int i = 0; i <= DIM; i++) ct_mem[i] = CW'($urandom_range(0, Q - 1));
    endtask

    task automatic load_simple(input int b, input int a0, input int s0);
        for (int i = 0; i < DIM; i++) sk_mem[i] = '0;
        for (int i = 0; i < DIM; i++) ct_mem[i] = CW'($urandom_range(0, Q - 1));
        ct_mem[0]   = CW'(a0);
        sk_mem[0]   = CW'(s0);
        ct_mem[DIM] = CW'(b);
    endtask

    // Called #1 after a posedge. Start is sampled at the next edge (edge 0);
    // returns the edge at which a consumer first samples result_valid high.
    task automatic start_and_wait(output int vedge);
        int n;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (result_valid !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        vedge = n + 1;
    endtask

    task automatic handshake();
        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, sk_rd_en, ct_rd_en, result_valid} !== 4'b0 || result !== '0 ||
            sk_addr !== '0 || ct_addr !== '0) begin
            failures++;
            $display("FAIL reset_outputs: busy=%b sk_en=%b ct_en=%b valid=%b result=%0d sk_addr=%0d ct_addr=%0d, required all 0",
                     busy, sk_rd_en, ct_rd_en, result_valid, result, sk_addr, ct_addr);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic_walk();
        int e;
        load_simple(512, 0, 0);
        for (int i = 0; i < DIM; i++) ct_mem[i] = CW'($urandom_range(0, Q - 1));
        ct_log.delete(); sk_log.delete();
        start_and_wait(e);
        checks++;
        if (e !== EXP_EDGE) begin
            failures++;
            $display("FAIL basic_latency: valid at edge %0d, required %0d", e, EXP_EDGE);
        end
        checks++;
        if (result !== PW'(32)) begin
            failures++;
            $display("FAIL basic_result: got %0d, required 32", result);
        end
        checks++;
        if (ct_log.size() != DIM + 1) begin
            failures++;
            $display("FAIL ct_walk_len: got %0d reads, required %0d", ct_log.size(), DIM + 1);
        end else begin
            for (int i = 0; i <= DIM; i++) begin
                checks++;
                if (ct_log[i] !== 4'(i)) begin
                    failures++;
                    $display("FAIL ct_walk[%0d]: got %0d, required %0d", i, ct_log[i], i);
                end
            end
        end
        checks++;
        if (sk_log.size() != DIM) begin
            failures++;
            $display("FAIL sk_walk_len: got %0d reads, required %0d", sk_log.size(), DIM);
        end else begin
            for (int i = 0; i < DIM; i++) begin
                checks++;
                if (sk_log[i] !== 4'(i)) begin
                    failures++;
                    $display("FAIL sk_walk[%0d]: got %0d, required %0d", i, sk_log[i], i);
                end
            end
        end
        handshake();
    endtask

    task automatic test_rounding();
        int bs  [5] = '{8, 7, 1020, 1015, 24};
        int exp [5] = '{1, 0, 0, 63, 2};
        int e;
        for (int k = 0; k < 5; k++) begin
            load_simple(bs[k], 0, 0);
            start_and_wait(e);
            checks++;
            if (e !== EXP_EDGE || result !== PW'(exp[k])) begin
                failures++;
                $display("FAIL round_b%0d: result=%0d edge=%0d, required result=%0d edge=%0d",
                         bs[k], result, e, exp[k], EXP_EDGE);
            end
            handshake();
        end
    endtask

    task automatic test_small_products();
        int bs [2] = '{100, 0};
        int as [2] = '{3, 1};
        int ss [2] = '{5, 1};
        int ex [2] = '{5, 0};
        int e;
        for (int k = 0; k < 2; k++) begin
            load_simple(bs[k], as[k], ss[k]);
            start_and_wait(e);
            checks++;
            if (result !== PW'(ex[k])) begin
                failures++;
                $display("FAIL small_prod%0d: got %0d, required %0d", k, result, ex[k]);
            end
            handshake();
        end
    endtask

    task automatic test_random();
        int e, exp;
        for (int k = 0; k < 20; k++) begin
            load_random();
            exp = model_result();
            start_and_wait(e);
            checks++;
            if (e !== EXP_EDGE || result !== PW'(exp)) begin
                failures++;
                $display("FAIL random%0d: result=%0d edge=%0d, required result=%0d edge=%0d",
                         k, result, e, exp, EXP_EDGE);
            end
            // Random idle gap before the next request.
            handshake();
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #0;
        end
    endtask

    task automatic test_hold();
        int e, exp, nct, nsk;
        load_random();
        exp = model_result();
        start_and_wait(e);
        nct = ct_log.size();
        nsk = sk_log.size();
        for (int c = 0; c < 20; c++) begin
            start = (c == 10);
            @(posedge clk); #1;
            checks++;
            if (result_valid !== 1'b1 || result !== PW'(exp) || busy !== 1'b1 ||
                ct_log.size() != nct || sk_log.size() != nsk) begin
                failures++;
                $display("FAIL hold_c%0d: valid=%b result=%0d busy=%b reads=%0d/%0d, required valid=1 result=%0d busy=1 reads=%0d/%0d",
                         c, result_valid, result, busy, ct_log.size(), sk_log.size(), exp, nct, nsk);
            end
        end
        // Handshake with start in the same cycle: start must be dropped.
        start = 1'b1;
        result_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        result_ready = 1'b0;
        checks++;
        if (busy !== 1'b0 || result_valid !== 1'b0) begin
            failures++;
            $display("FAIL hold_release: busy=%b valid=%b, required 0 0", busy, result_valid);
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || ct_log.size() != nct || sk_log.size() != nsk) begin
            failures++;
            $display("FAIL start_ignored: busy=%b reads=%0d/%0d, required 0 and %0d/%0d",
                     busy, ct_log.size(), sk_log.size(), nct, nsk);
        end
        // Stray ready while idle must do nothing.
        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
        checks++;
        if (busy !== 1'b0 || result_valid !== 1'b0) begin
            failures++;
            $display("FAIL idle_ready: busy=%b valid=%b, required 0 0", busy, result_valid);
        end
    endtask

    task automatic test_reset_mid();
        int e, exp, n;
        load_random();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!(ct_rd_en === 1'b1 && ct_addr === 4'd4) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n >= 50) begin
            failures++;
            $display("FAIL reach_index4: ct_addr=%0d, required 4 within 50 cycles", ct_addr);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({busy, sk_rd_en, ct_rd_en, result_valid} !== 4'b0 || sk_addr !== '0 || ct_addr !== '0) begin
            failures++;
            $display("FAIL midreset_outputs: busy=%b sk_en=%b ct_en=%b valid=%b sk_addr=%0d ct_addr=%0d, required all 0",
                     busy, sk_rd_en, ct_rd_en, result_valid, sk_addr, ct_addr);
        end
        rst = 1'b0;
        load_random();
        exp = model_result();
        start_and_wait(e);
        checks++;
        if (e !== EXP_EDGE || result !== PW'(exp)) begin
            failures++;
            $display("FAIL after_reset: result=%0d edge=%0d, required result=%0d edge=%0d",
                     result, e, exp, EXP_EDGE);
        end
        handshake();
    endtask

    task automatic test_back_to_back();
        int e1, e2, exp1, exp2;
        load_random();
        exp1 = model_result();
        start_and_wait(e1);
        checks++;
        if (e1 !== EXP_EDGE || result !== PW'(exp1)) begin
            failures++;
            $display("FAIL b2b_first: result=%0d edge=%0d, required result=%0d edge=%0d",
                     result, e1, exp1, EXP_EDGE);
        end
        // Fetch is over; swap in the second operand set before releasing.
        load_random();
        exp2 = model_result();
        handshake();
        start_and_wait(e2);
        checks++;
        if (e2 !== EXP_EDGE || result !== PW'(exp2)) begin
            failures++;
            $display("FAIL b2b_second: result=%0d edge=%0d, required result=%0d edge=%0d",
                     result, e2, exp2, EXP_EDGE);
        end
        handshake();
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        result_ready = 1'b0;
        for (int i = 0; i < DIM; i++) sk_mem[i] = '0;
        for (int i = 0; i <= DIM; i++) ct_mem[i] = '0;
        test_reset();
        test_basic_walk();
        test_rounding();
        test_small_products();
        test_random();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
